// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, 1-cycle-latency imem requests, IF/ID register,
// and a 1-entry skid buffer so responses arriving during a stall are never lost.
module if_fetch_stage #(
   parameter int unsigned          XLEN     = 32,
   parameter logic [XLEN-1:0]      RESET_PC = '0,
   parameter int unsigned          PC_STEP  = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic            if_valid_o,
   output logic [XLEN-1:0] if_pc_o,
   output logic [XLEN-1:0] if_instr_o,
   output logic [XLEN-1:0] if_pc_next_o
);

   localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

   logic [XLEN-1:0] pc_q, pc_d;
   logic            infl_q, infl_d;
   logic [XLEN-1:0] infl_pc_q, infl_pc_d;
   logic            skid_v_q, skid_v_d;
   logic [XLEN-1:0] skid_pc_q, skid_pc_d;
   logic [XLEN-1:0] skid_instr_q, skid_instr_d;
   logic            valid_q, valid_d;
   logic [XLEN-1:0] id_pc_q, id_pc_d;
   logic [XLEN-1:0] id_instr_q, id_instr_d;
   logic [XLEN-1:0] id_pc_next_q, id_pc_next_d;

   // Control contract: stall_i=1 freezes IF/ID and suppresses new requests; redirect_i=1
   // overrides stall, flushes IF/ID and skid, drops the in-flight response and fetches
   // redirect_pc_i. A request issued at one edge returns imem_rdata_i during the next cycle.
   always_comb begin
      imem_req_o  = rst_n & (redirect_i | (~stall_i & (~skid_v_q | ~infl_q)));
      imem_addr_o = redirect_i ? redirect_pc_i : pc_q;

      pc_d         = pc_q;
      infl_d       = imem_req_o;
      infl_pc_d    = infl_pc_q;
      skid_v_d     = skid_v_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      valid_d      = valid_q;
      id_pc_d      = id_pc_q;
      id_instr_d   = id_instr_q;
      id_pc_next_d = id_pc_next_q;

      if (imem_req_o) begin
         pc_d      = imem_addr_o + STEP;
         infl_pc_d = imem_addr_o;
      end

      if (redirect_i) begin
         valid_d  = 1'b0;
         skid_v_d = 1'b0;
      end else if (stall_i) begin
         if (infl_q) begin
            skid_v_d     = 1'b1;
            skid_pc_d    = infl_pc_q;
            skid_instr_d = imem_rdata_i;
         end
      end else if (skid_v_q) begin
         valid_d      = 1'b1;
         id_pc_d      = skid_pc_q;
         id_instr_d   = skid_instr_q;
         id_pc_next_d = skid_pc_q + STEP;
         skid_v_d     = 1'b0;
         // A response landing on the drain edge refills the skid behind the drained word.
         if (infl_q) begin
            skid_v_d     = 1'b1;
            skid_pc_d    = infl_pc_q;
            skid_instr_d = imem_rdata_i;
         end
      end else if (infl_q) begin
         valid_d      = 1'b1;
         id_pc_d      = infl_pc_q;
         id_instr_d   = imem_rdata_i;
         id_pc_next_d = infl_pc_q + STEP;
      end else begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         infl_q       <= 1'b0;
         infl_pc_q    <= '0;
         skid_v_q     <= 1'b0;
         skid_pc_q    <= '0;
         skid_instr_q <= '0;
         valid_q      <= 1'b0;
         id_pc_q      <= '0;
         id_instr_q   <= '0;
         id_pc_next_q <= '0;
      end else begin
         pc_q         <= pc_d;
         infl_q       <= infl_d;
         infl_pc_q    <= infl_pc_d;
         skid_v_q     <= skid_v_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
         valid_q      <= valid_d;
         id_pc_q      <= id_pc_d;
         id_instr_q   <= id_instr_d;
         id_pc_next_q <= id_pc_next_d;
      end
   end

   assign if_valid_o   = valid_q;
   assign if_pc_o      = id_pc_q;
   assign if_instr_o   = id_instr_q;
   assign if_pc_next_o = id_pc_next_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: per-cycle vector table plus a hand-written
// asynchronous reset pulse sequence.
module tb_if_fetch_stage;

   localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

   logic        clk;
   logic        rst_n;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_rdata_i;
   logic        if_valid_o;
   logic [31:0] if_pc_o;
   logic [31:0] if_instr_o;
   logic [31:0] if_pc_next_o;

   int checks = 0;
   int errors = 0;

   if_fetch_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall_i      (stall_i),
      .redirect_i   (redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_rdata_i (imem_rdata_i),
      .if_valid_o   (if_valid_o),
      .if_pc_o      (if_pc_o),
      .if_instr_o   (if_instr_o),
      .if_pc_next_o (if_pc_next_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // synchronous instruction memory: data = addr ^ key, one cycle after the request
   always @(posedge clk) begin
      if (imem_req_o) imem_rdata_i <= imem_addr_o ^ XOR_KEY;
   end

   typedef struct {
      logic        stall;
      logic        redirect;
      logic [31:0] rpc;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs[21];

   function automatic vec_t mk(logic st, logic rd, logic [31:0] rpc, logic req,
                               logic [31:0] addr, logic v, logic [31:0] pc);
      vec_t r;
      r.stall = st; r.redirect = rd; r.rpc = rpc; r.exp_req = req;
      r.exp_addr = addr; r.exp_valid = v; r.exp_pc = pc;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_id(input string tag, input logic [31:0] pc);
      chk({tag, " pc"}, if_pc_o, pc);
      chk({tag, " instr"}, if_instr_o, pc ^ XOR_KEY);
      chk({tag, " pc_next"}, if_pc_next_o, pc + 32'd4);
   endtask

   task automatic drive(input logic st, input logic rd, input logic [31:0] rpc);
      stall_i       = st;
      redirect_i    = rd;
      redirect_pc_i = rpc;
   endtask

   initial begin
      //           stall redir rpc           req addr          valid pc
      vecs[0]  = mk(0, 0, 32'h0,          1, 32'h0,         0, 32'h0);
      vecs[1]  = mk(0, 0, 32'h0,          1, 32'h4,         1, 32'h0);
      vecs[2]  = mk(0, 0, 32'h0,          1, 32'h8,         1, 32'h4);
      vecs[3]  = mk(0, 0, 32'h0,          1, 32'hC,         1, 32'h8);
      vecs[4]  = mk(1, 0, 32'h0,          0, 32'h10,        1, 32'h8);
      vecs[5]  = mk(1, 0, 32'h0,          0, 32'h10,        1, 32'h8);
      vecs[6]  = mk(1, 0, 32'h0,          0, 32'h10,        1, 32'h8);
      vecs[7]  = mk(0, 0, 32'h0,          1, 32'h10,        1, 32'hC);
      vecs[8]  = mk(0, 0, 32'h0,          1, 32'h14,        1, 32'h10);
      vecs[9]  = mk(0, 0, 32'h0,          1, 32'h18,        1, 32'h14);
      vecs[10] = mk(0, 1, 32'h100,        1, 32'h100,       0, 32'h0);
      vecs[11] = mk(0, 0, 32'h0,          1, 32'h104,       1, 32'h100);
      vecs[12] = mk(0, 0, 32'h0,          1, 32'h108,       1, 32'h104);
      vecs[13] = mk(1, 0, 32'h0,          0, 32'h10C,       1, 32'h104);
      vecs[14] = mk(1, 1, 32'h200,        1, 32'h200,       0, 32'h0);
      vecs[15] = mk(1, 0, 32'h0,          0, 32'h204,       0, 32'h0);
      vecs[16] = mk(0, 0, 32'h0,          1, 32'h204,       1, 32'h200);
      vecs[17] = mk(0, 0, 32'h0,          1, 32'h208,       1, 32'h204);
      vecs[18] = mk(0, 1, 32'hFFFF_FFFC,  1, 32'hFFFF_FFFC, 0, 32'h0);
      vecs[19] = mk(0, 0, 32'h0,          1, 32'h0,         1, 32'hFFFF_FFFC);
      vecs[20] = mk(0, 0, 32'h0,          1, 32'h4,         1, 32'h0);

      // reset state
      rst_n = 1'b0;
      drive(0, 0, 32'h0);
      #12;
      chk("reset req", {31'b0, imem_req_o}, 32'd0);
      chk("reset valid", {31'b0, if_valid_o}, 32'd0);
      chk("reset pc", if_pc_o, 32'h0);
      chk("reset instr", if_instr_o, 32'h0);
      chk("reset pc_next", if_pc_next_o, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // table: inputs set at negedge, request checked before the edge, IF/ID after it
      for (int i = 0; i < 21; i++) begin
         drive(vecs[i].stall, vecs[i].redirect, vecs[i].rpc);
         #1;
         chk($sformatf("v%0d req", i), {31'b0, imem_req_o}, {31'b0, vecs[i].exp_req});
         chk($sformatf("v%0d addr", i), imem_addr_o, vecs[i].exp_addr);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d valid", i), {31'b0, if_valid_o}, {31'b0, vecs[i].exp_valid});
         if (vecs[i].exp_valid) chk_id($sformatf("v%0d", i), vecs[i].exp_pc);
         @(negedge clk);
      end

      // sub-cycle reset pulse mid-stream: outputs clear before any edge
      drive(0, 0, 32'h0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("pulse valid", {31'b0, if_valid_o}, 32'd0);
      chk("pulse req", {31'b0, imem_req_o}, 32'd0);
      chk("pulse pc", if_pc_o, 32'h0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("restart addr", imem_addr_o, 32'h0);
      chk("restart req", {31'b0, imem_req_o}, 32'd1);
      @(posedge clk); #1;
      chk("restart valid e1", {31'b0, if_valid_o}, 32'd0);
      @(posedge clk); #1;
      chk("restart valid e2", {31'b0, if_valid_o}, 32'd1);
      chk_id("restart e2", 32'h0);
      @(posedge clk); #1;
      chk("restart valid e3", {31'b0, if_valid_o}, 32'd1);
      chk_id("restart e3", 32'h4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
